// File: rtl/pie_preamble_encoder_pkg.sv
// Shared types and helpers for the Gen2 PIE preamble/frame-sync encoder.
// Symbol lengths are in output samples; RTCAL is derived from TARI and DATA1.
package pie_preamble_encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELIM,
    ST_DATA0,
    ST_RTCAL,
    ST_TRCAL,
    ST_BITS
  } state_e;

  function automatic int rtcal_len(input int tari, input int data1);
    return tari + data1;
  endfunction

  // Length of the segment currently being emitted; bit_val only matters in ST_BITS.
  function automatic int sym_len(input state_e st, input logic bit_val, input int tari,
                                 input int data1, input int delim, input int trcal);
    int len;
    len = tari;
    case (st)
      ST_DELIM: len = delim;
      ST_DATA0: len = tari;
      ST_RTCAL: len = rtcal_len(tari, data1);
      ST_TRCAL: len = trcal;
      ST_BITS:  len = bit_val ? data1 : tari;
      default:  len = tari;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/pie_preamble_encoder_if.sv
// Request, bit-stream and envelope signals of the PIE encoder.
// The master side issues frames and bits; the slave side is the encoder.
interface pie_preamble_encoder_if #(
  parameter int LEN_WIDTH = 8
) ();
  logic                 start;
  logic                 preamble;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic                 in_dat;
  logic                 in_vld;
  logic                 in_rdy;
  logic                 out_dat;
  logic                 out_vld;
  logic                 busy;
  logic                 done;
  logic                 underrun;

  modport master (
    output start, preamble, cmd_len, in_dat, in_vld,
    input  in_rdy, out_dat, out_vld, busy, done, underrun
  );

  modport slave (
    input  start, preamble, cmd_len, in_dat, in_vld,
    output in_rdy, out_dat, out_vld, busy, done, underrun
  );
endinterface

// File: rtl/pie_preamble_encoder_sample_tick_gen.sv
// Free-running clock divider: tick_o is high on the terminal count, once every
// CLKS_PER_SAMPLE cycles (every cycle when CLKS_PER_SAMPLE is 1).
module pie_preamble_encoder_sample_tick_gen #(
  parameter int CLKS_PER_SAMPLE = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);
  localparam int DW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    tick_o = (div_q == DW'(CLKS_PER_SAMPLE - 1));
    div_d  = tick_o ? '0 : div_q + DW'(1);
  end

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end
endmodule

// File: rtl/pie_preamble_encoder.sv
// Gen2 reader transmit framer: delimiter, data-0, RTcal, optional TRcal, then one
// PIE symbol per command bit, as a registered 1-bit carrier envelope.
module pie_preamble_encoder
  import pie_preamble_encoder_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 4,
  parameter int TARI            = 8,
  parameter int DATA1           = 14,
  parameter int PW              = 4,
  parameter int DELIM           = 4,
  parameter int TRCAL           = 48,
  parameter int LEN_WIDTH       = 8
) (
  input  logic clk,
  input  logic rst,
  pie_preamble_encoder_if.slave bus
);
  localparam int CW = $clog2(TRCAL + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pre_q, pre_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] fetched_q, fetched_d;
  logic                 buf_vld_q, buf_vld_d;
  logic                 buf_dat_q, buf_dat_d;
  logic                 cur_bit_q, cur_bit_d;
  logic                 out_dat_q, out_dat_d;
  logic                 out_vld_q, out_vld_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 underrun_q, underrun_d;

  logic                 tick;
  logic                 in_rdy_c;
  logic                 sym_bit_c;
  logic [CW-1:0]        len_c;
  logic                 last_c;
  logic                 more_c;
  logic                 sample_c;

  pie_preamble_encoder_sample_tick_gen #(
    .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    len_d      = len_q;
    fetched_d  = fetched_q;
    buf_vld_d  = buf_vld_q;
    buf_dat_d  = buf_dat_q;
    cur_bit_d  = cur_bit_q;
    out_dat_d  = out_dat_q;
    out_vld_d  = tick;
    busy_d     = (state_q != ST_IDLE);
    done_d     = 1'b0;
    underrun_d = 1'b0;

    in_rdy_c  = !buf_vld_q && (fetched_q < len_q) && (state_q != ST_IDLE);
    // The bit under way is still in the buffer on the first sample of its symbol.
    sym_bit_c = (cnt_q == '0) ? buf_dat_q : cur_bit_q;
    len_c     = CW'(sym_len(state_q, sym_bit_c, TARI, DATA1, DELIM, TRCAL));
    last_c    = (cnt_q == len_c - CW'(1));
    more_c    = (fetched_q < len_q) || buf_vld_q;

    case (state_q)
      ST_IDLE:  sample_c = 1'b1;
      ST_DELIM: sample_c = 1'b0;
      default:  sample_c = (cnt_q < len_c - CW'(PW));
    endcase

    if (in_rdy_c && bus.in_vld) begin
      buf_vld_d = 1'b1;
      buf_dat_d = bus.in_dat;
      fetched_d = fetched_q + LEN_WIDTH'(1);
    end

    if (state_q == ST_IDLE) begin
      if (bus.start && !busy_q) begin
        state_d   = ST_DELIM;
        cnt_d     = '0;
        pre_d     = bus.preamble;
        len_d     = bus.cmd_len;
        fetched_d = '0;
        buf_vld_d = 1'b0;
        busy_d    = 1'b1;
      end
      if (tick) out_dat_d = 1'b1;
    end else if (tick) begin
      out_dat_d = sample_c;
      if (state_q == ST_BITS && cnt_q == '0) begin
        cur_bit_d = buf_dat_q;
        buf_vld_d = 1'b0;
      end
      if (!last_c) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
        case (state_q)
          ST_DELIM: state_d = ST_DATA0;
          ST_DATA0: state_d = ST_RTCAL;
          default: begin
            if (state_q == ST_RTCAL && pre_q) begin
              state_d = ST_TRCAL;
            end else if (!more_c) begin
              state_d   = ST_IDLE;
              done_d    = 1'b1;
              buf_vld_d = 1'b0;
            end else if (!buf_vld_q) begin
              state_d    = ST_IDLE;
              underrun_d = 1'b1;
              buf_vld_d  = 1'b0;
            end else begin
              state_d = ST_BITS;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pre_q      <= 1'b0;
      len_q      <= '0;
      fetched_q  <= '0;
      buf_vld_q  <= 1'b0;
      buf_dat_q  <= 1'b0;
      cur_bit_q  <= 1'b0;
      out_dat_q  <= 1'b1;
      out_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      len_q      <= len_d;
      fetched_q  <= fetched_d;
      buf_vld_q  <= buf_vld_d;
      buf_dat_q  <= buf_dat_d;
      cur_bit_q  <= cur_bit_d;
      out_dat_q  <= out_dat_d;
      out_vld_q  <= out_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.in_rdy   = in_rdy_c;
  assign bus.out_dat  = out_dat_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_pie_preamble_encoder.sv
// Directed bench for pie_preamble_encoder: three instances (4, 1 and 7 clocks per
// sample) share one monitor selected by sel; expected envelopes come from symbol lengths.
module tb_pie_preamble_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         sel = 0;
  logic       start_d = 1'b0;
  logic       pre_d = 1'b0;
  logic [7:0] len_d = '0;
  logic       dat_d = 1'b0;
  logic       vld_d = 1'b0;

  always #5 clk = ~clk;

  pie_preamble_encoder_if #(.LEN_WIDTH(8)) if0 ();
  pie_preamble_encoder_if #(.LEN_WIDTH(8)) if1 ();
  pie_preamble_encoder_if #(.LEN_WIDTH(8)) if7 ();

  assign if0.start = start_d && (sel == 0);
  assign if1.start = start_d && (sel == 1);
  assign if7.start = start_d && (sel == 2);
  assign if0.preamble = pre_d;
  assign if1.preamble = pre_d;
  assign if7.preamble = pre_d;
  assign if0.cmd_len = len_d;
  assign if1.cmd_len = len_d;
  assign if7.cmd_len = len_d;
  assign if0.in_dat = dat_d;
  assign if1.in_dat = dat_d;
  assign if7.in_dat = dat_d;
  assign if0.in_vld = vld_d && (sel == 0);
  assign if1.in_vld = vld_d && (sel == 1);
  assign if7.in_vld = vld_d && (sel == 2);

  pie_preamble_encoder #(.CLKS_PER_SAMPLE(4)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  pie_preamble_encoder #(.CLKS_PER_SAMPLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  pie_preamble_encoder #(.CLKS_PER_SAMPLE(7)) u_dut7 (.clk(clk), .rst(rst), .bus(if7));

  logic mon_vld, mon_dat, mon_done, mon_urun, mon_busy, mon_rdy;
  always_comb begin
    case (sel)
      1: begin
        mon_vld = if1.out_vld; mon_dat = if1.out_dat; mon_done = if1.done;
        mon_urun = if1.underrun; mon_busy = if1.busy; mon_rdy = if1.in_rdy;
      end
      2: begin
        mon_vld = if7.out_vld; mon_dat = if7.out_dat; mon_done = if7.done;
        mon_urun = if7.underrun; mon_busy = if7.busy; mon_rdy = if7.in_rdy;
      end
      default: begin
        mon_vld = if0.out_vld; mon_dat = if0.out_dat; mon_done = if0.done;
        mon_urun = if0.underrun; mon_busy = if0.busy; mon_rdy = if0.in_rdy;
      end
    endcase
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor state, sampled on the falling edge.
  bit samples[$];
  bit exp_q[$];
  int cyc, last_vld, min_gap, max_gap;
  int done_cnt, urun_cnt, done_busy, post_busy, urun_vld, urun_dat, rdy_seen;
  bit chk_next;

  task automatic clear_mon();
    samples.delete();
    exp_q.delete();
    last_vld = -1; min_gap = 1000; max_gap = 0;
    done_cnt = 0; urun_cnt = 0; done_busy = -1; post_busy = -1;
    urun_vld = -1; urun_dat = -1; rdy_seen = 0; chk_next = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_vld) begin
      samples.push_back(mon_dat);
      if (last_vld >= 0) begin
        if (cyc - last_vld < min_gap) min_gap = cyc - last_vld;
        if (cyc - last_vld > max_gap) max_gap = cyc - last_vld;
      end
      last_vld = cyc;
    end
    if (mon_rdy) rdy_seen = 1;
    if (chk_next) begin
      post_busy = mon_busy;
      chk_next  = 0;
    end
    if (mon_done) begin
      done_cnt++;
      done_busy = mon_busy;
      chk_next  = 1;
    end
    if (mon_urun) begin
      urun_cnt++;
      urun_vld = mon_vld;
      urun_dat = mon_dat;
    end
  end

  task automatic add_low(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
  endtask

  // PIE symbol: L-4 high samples followed by a 4-sample low pulse.
  task automatic add_sym(input int len);
    for (int i = 0; i < len - 4; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
  endtask

  task automatic build_preamble(input bit pre);
    add_low(4);
    add_sym(8);
    add_sym(22);
    if (pre) add_sym(48);
  endtask

  task automatic pulse_start(input bit pre, input int len);
    @(posedge clk); #1;
    start_d = 1'b1; pre_d = pre; len_d = 8'(len);
    @(posedge clk); #1;
    start_d = 1'b0;
  endtask

  task automatic feed(input bit b);
    int n = 0;
    dat_d = b; vld_d = 1'b1;
    @(negedge clk);
    while (!mon_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("feed_rdy", int'(mon_rdy), 1);
    @(posedge clk); #1;
    vld_d = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int limit);
    int n = 0;
    while (done_cnt + urun_cnt == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ended"}, int'(done_cnt + urun_cnt > 0), 1);
    repeat (30) @(negedge clk);
  endtask

  task automatic cmp_stream(input string tag);
    int i = 0;
    int bad = 0;
    int tail;
    while (i < samples.size() && samples[i] == 1'b1) i++;
    for (int j = 0; j < exp_q.size(); j++)
      if (i + j >= samples.size() || samples[i + j] !== exp_q[j]) bad++;
    check({tag, "_samples"}, bad, 0);
    tail = (i + exp_q.size() < samples.size()) ? int'(samples[i + exp_q.size()]) : -1;
    check({tag, "_tail_cw"}, tail, 1);
  endtask

  initial begin
    int n;
    cyc = 0;
    clear_mon();

    // Reset with start held high: reset wins, outputs at reset values.
    start_d = 1'b1; pre_d = 1'b1; len_d = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_out_dat", int'(if0.out_dat), 1);
    check("rst_out_vld", int'(if0.out_vld), 0);
    check("rst_in_rdy", int'(if0.in_rdy), 0);
    check("rst_busy", int'(if0.busy), 0);
    check("rst_done", int'(if0.done), 0);
    check("rst_underrun", int'(if0.underrun), 0);
    start_d = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_busy", int'(if0.busy), 0);
    check("idle_no_low", int'(samples.size() > 0 && samples.find_first_index(x) with (x == 1'b0).size() == 0), 1);

    // A: full preamble, no command bits.
    clear_mon();
    build_preamble(1'b1);
    pulse_start(1'b1, 0);
    wait_end("a", 2000);
    cmp_stream("a");
    check("a_done_cnt", done_cnt, 1);
    check("a_urun_cnt", urun_cnt, 0);
    check("a_busy_at_done", done_busy, 1);
    check("a_busy_after_done", post_busy, 0);
    check("a_gap_min", min_gap, 4);
    check("a_gap_max", max_gap, 4);
    check("a_rdy_never", rdy_seen, 0);

    // B: frame-sync, two bits 1,0 supplied immediately.
    clear_mon();
    build_preamble(1'b0);
    add_sym(14);
    add_sym(8);
    pulse_start(1'b0, 2);
    feed(1'b1);
    feed(1'b0);
    wait_end("b", 2000);
    cmp_stream("b");
    check("b_done_cnt", done_cnt, 1);
    check("b_urun_cnt", urun_cnt, 0);

    // C: three bits requested, only the first supplied.
    clear_mon();
    build_preamble(1'b0);
    add_sym(14);
    pulse_start(1'b0, 3);
    feed(1'b1);
    wait_end("c", 2000);
    cmp_stream("c");
    check("c_urun_cnt", urun_cnt, 1);
    check("c_done_cnt", done_cnt, 0);
    check("c_urun_on_sample", urun_vld, 1);
    check("c_urun_last_low", urun_dat, 0);
    check("c_busy_end", int'(mon_busy), 0);
    check("c_rdy_end", int'(mon_rdy), 0);

    // D: start re-pulsed mid-frame must not disturb the frame of B.
    clear_mon();
    build_preamble(1'b0);
    add_sym(14);
    add_sym(8);
    pulse_start(1'b0, 2);
    feed(1'b1);
    pulse_start(1'b1, 5);
    feed(1'b0);
    repeat (60) @(posedge clk);
    pulse_start(1'b1, 5);
    wait_end("d", 2000);
    cmp_stream("d");
    check("d_done_cnt", done_cnt, 1);
    check("d_urun_cnt", urun_cnt, 0);

    // E: reset inside the TRcal high segment, then a clean frame.
    clear_mon();
    pulse_start(1'b1, 0);
    n = 0;
    while (samples.size() < 46 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("e_reached_trcal", int'(samples.size() >= 46), 1);
    check("e_busy_before", int'(mon_busy), 1);
    rst = 1'b1;
    #1;
    check("e_rst_out_dat", int'(mon_dat), 1);
    check("e_rst_busy", int'(mon_busy), 0);
    check("e_rst_out_vld", int'(mon_vld), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    build_preamble(1'b1);
    pulse_start(1'b1, 0);
    wait_end("e", 2000);
    cmp_stream("e");
    check("e_done_cnt", done_cnt, 1);

    // F: one and seven clocks per sample give the same envelope.
    sel = 1;
    clear_mon();
    build_preamble(1'b1);
    pulse_start(1'b1, 0);
    wait_end("f1", 2000);
    cmp_stream("f1");
    check("f1_done_cnt", done_cnt, 1);
    check("f1_gap_min", min_gap, 1);
    check("f1_gap_max", max_gap, 1);

    sel = 2;
    clear_mon();
    build_preamble(1'b1);
    pulse_start(1'b1, 0);
    wait_end("f7", 4000);
    cmp_stream("f7");
    check("f7_done_cnt", done_cnt, 1);
    check("f7_gap_min", min_gap, 7);
    check("f7_gap_max", max_gap, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
